// File: rtl/parity_seq_gen.sv
// Streams COUNT words of one parity (even or odd), stepping by 2 with wrap, over a valid/ready port.
// Optional parity monitor and sticky err output: define PARITY_SEQ_GEN_CHECK_EN.
module parity_seq_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             want_even,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
`ifdef PARITY_SEQ_GEN_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_rem;

    logic             w_xfer;
    logic             w_accept;
    logic             w_cnt_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_first;

    assign w_xfer     = r_valid & out_ready;
    assign w_accept   = (r_state == S_IDLE) & start;
    assign w_cnt_zero = (count == '0);
    assign w_last     = (r_rem == CNT_W'(1));
    // Bump the seed to the next value when its LSB has the wrong parity.
    assign w_first    = (seed[0] == ~want_even) ? seed : seed + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_cnt_zero ? S_FIN : S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_xfer && w_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_rem   <= '0;
        end else if (w_accept && !w_cnt_zero) begin
            r_data  <= w_first;
            r_valid <= 1'b1;
            r_rem   <= count;
        end else if ((r_state == S_EMIT) && w_xfer) begin
            if (w_last) begin
                r_valid <= 1'b0;
                r_rem   <= '0;
            end else begin
                r_data <= r_data + WIDTH'(2);
                r_rem  <= r_rem - CNT_W'(1);
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);

`ifdef PARITY_SEQ_GEN_CHECK_EN
    logic r_want_even;
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_want_even <= 1'b0;
        end else if (w_accept) begin
            r_want_even <= want_even;
        end
    end

    // Monitor watches the output port itself so any corruption on the way out is caught.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (out_valid && out_ready && (out_data[0] != ~r_want_even)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_parity_seq_gen.sv
// Directed bench for parity_seq_gen: expected words queued at start, checked on each transfer.
module tb_parity_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       want_even = 1'b0;
    logic [7:0] seed = 8'd0;
    logic [7:0] count = 8'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
`ifdef PARITY_SEQ_GEN_CHECK_EN
    logic       err;
    logic [7:0] fv;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    parity_seq_gen #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .want_even (want_even),
        .seed      (seed),
        .count     (count),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef PARITY_SEQ_GEN_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs are already set for the coming edge; score the transfer that edge will make.
    task automatic step();
        logic [7:0] e;
        if (out_valid && out_ready) begin
            chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data", 32'(out_data), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_req(input logic [7:0] s, input logic we, input logic [7:0] c);
        seed      = s;
        want_even = we;
        count     = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Basic even stream with one word per cycle
        exp_q.push_back(8'd10); exp_q.push_back(8'd12);
        exp_q.push_back(8'd14); exp_q.push_back(8'd16);
        start_req(8'd10, 1'b1, 8'd4);
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'(out_data), 32'd10);
        repeat (4) step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_fin", 32'(busy), 32'd1);
        chk("t1_valid_fin", 32'(out_valid), 32'd0);
        step();
        chk("t1_done_once", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Seed adjustment across wrap, then odd wrap 255 -> 1
        exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd4);
        start_req(8'd255, 1'b1, 8'd3);
        drain(20);
        step();
        chk("t2a_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(8'd253); exp_q.push_back(8'd255); exp_q.push_back(8'd1);
        start_req(8'd253, 1'b0, 8'd3);
        drain(20);
        step();
        chk("t2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure holds the first word stable
        exp_q.push_back(8'd7); exp_q.push_back(8'd9); exp_q.push_back(8'd11);
        out_ready = 1'b0;
        start_req(8'd6, 1'b0, 8'd3);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_data", 32'(out_data), 32'd7);
        repeat (3) begin
            step();
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_data", 32'(out_data), 32'd7);
        end
        out_ready = 1'b1;
        drain(20);
        step();
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length request
        start_req(8'd5, 1'b1, 8'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        step();
        chk("t4_done_once", 32'(done), 32'd0);
        chk("t4_busy_off", 32'(busy), 32'd0);
        chk("t4_valid_off", 32'(out_valid), 32'd0);

        // Start while busy is ignored
        exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd4);
        exp_q.push_back(8'd6); exp_q.push_back(8'd8);
        start_req(8'd0, 1'b1, 8'd5);
        step();
        step();
        seed      = 8'd100;
        want_even = 1'b0;
        count     = 8'd1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        drain(20);
        chk("t5a_q_empty", 32'(exp_q.size()), 32'd0);
        step();
        chk("t5a_idle", 32'(busy), 32'd0);

        // Async reset mid-stream drops the word and suppresses done
        exp_q.push_back(8'd20); exp_q.push_back(8'd22); exp_q.push_back(8'd24);
        exp_q.push_back(8'd26); exp_q.push_back(8'd28);
        start_req(8'd20, 1'b1, 8'd5);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5b_rst_data", 32'(out_data), 32'd0);
        chk("t5b_rst_valid", 32'(out_valid), 32'd0);
        chk("t5b_rst_busy", 32'(busy), 32'd0);
        chk("t5b_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5b_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("t5b_idle_busy", 32'(busy), 32'd0);
        chk("t5b_idle_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(8'd4); exp_q.push_back(8'd6);
        start_req(8'd3, 1'b1, 8'd2);
        drain(20);
        step();
        chk("t5b_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef PARITY_SEQ_GEN_CHECK_EN
        chk("t6_err_clean", 32'(err), 32'd0);
        exp_q.push_back(8'd40); exp_q.push_back(8'd42);
        start_req(8'd40, 1'b1, 8'd2);
        fv = 8'd41;
        force dut.out_data = fv;
        @(posedge clk);
        @(negedge clk);
        void'(exp_q.pop_front());
        release dut.out_data;
        chk("t6_err_set", 32'(err), 32'd1);
        drain(20);
        step();
        chk("t6_err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_reset", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
